// File: rtl/prbs_burst_ctrl.sv
// ============================================================================
// Module   : prbs_burst_ctrl (with helper lfsr)
// Function : Bounded PRBS word burst from a Galois LFSR over a valid/ready stream
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr #(
  parameter int          LEN  = 8,
  parameter logic [LEN-1:0] TAPS = 8'b10111000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [LEN-1:0] seed,
  output logic [LEN-1:0] state
);
  logic [LEN-1:0] state_q, state_d;

  // A zero seed would lock the register, so it selects all ones instead.
  always_comb begin
    state_d = state_q;
    if (rst)
      state_d = (seed == '0) ? '1 : seed;
    else if (en)
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;
endmodule

module prbs_burst_ctrl #(
  parameter int             LEN  = 8,
  parameter logic [LEN-1:0] TAPS = 8'b10111000,
  parameter int             CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LEN-1:0]  seed,
  input  logic [CNTW-1:0] count,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LEN-1:0]  out_data,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LEN-1:0]  seed_q, seed_d;
  logic [CNTW-1:0] remaining_q, remaining_d;
  logic [LEN-1:0]  lfsr_state;
  logic            handshake;

  assign handshake = (state_q == STREAM) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            seed_d      = seed;
            remaining_d = count;
            state_d     = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD:   state_d = STREAM;
      STREAM: begin
        if (handshake) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNTW'(1))
            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over normal progress; a coincident handshake still steps the LFSR.
    if (abort && (state_q != IDLE))
      state_d = IDLE;
  end

  lfsr #(
    .LEN  (LEN),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (state_q == LOAD),
    .en    (handshake),
    .seed  (seed_q),
    .state (lfsr_state)
  );

  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? lfsr_state : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

`default_nettype wire

// File: doc/prbs_burst_ctrl.md
# prbs_burst_ctrl

Sequences one Galois LFSR to emit a bounded burst of pseudo-random words over a valid/ready stream. Used as the test-pattern source for optical link bring-up and BER measurement. The block owns the LFSR's seed load, step enable and word count, so downstream logic sees only a clean stream plus start/done control. It instantiates the team's `lfsr` module internally and drives that module's synchronous `rst`, `en` and `seed` inputs.

## Interface
- `LEN`, 8: LFSR and output word width.
- `TAPS`, 8'b10111000: Galois XOR taps, passed to the LFSR.
- `CNTW`, 16: width of the burst word count.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `seed`  in  LEN  seed captured with `start`. Zero selects the LFSR default seed (all ones).
- `count`  in  CNTW  number of words in the burst, captured with `start`.
- `abort`  in  1  terminates any burst in progress.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  LEN  current LFSR state. Forced to 0 whenever `out_valid` is 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a burst completes normally.

## Operation
- FSM states: IDLE, LOAD, STREAM, DONE. A 1-cycle LOAD guarantees that the LFSR `rst` is asserted before its `en`.
- **IDLE**
  - `start` with `count`≠0: latch `seed` and `count` into `remaining`, then go to LOAD.
  - `start` with `count`=0: go to DONE; no words are emitted.
  - `abort` has no effect here.
- **LOAD**
  - LFSR `rst`=1 with the latched seed; LFSR `en`=0.
  - Always go to STREAM next cycle.
- **STREAM**
  - `out_valid`=1 and `out_data`=LFSR state.
  - On handshake (`out_valid`&`out_ready`): LFSR `en`=1 and `remaining` decrements.
  - If a handshake occurs while `remaining`=1, go to DONE.
  - Without a handshake, the LFSR holds and `out_data` stays stable.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- Word k of a burst (k=0..count-1) is the LFSR state after k steps from the seed.
- `remaining` is CNTW bits wide, unsigned. The maximum burst is 2^CNTW−1 words. The count never wraps because the exit condition is `remaining`=1 at a handshake.
- **Abort**
  - In LOAD, STREAM or DONE: go to IDLE on the next edge, with no `done` pulse.
  - `out_valid` drops that edge.
  - If a handshake coincides with `abort`, the word counts as accepted and the LFSR steps. The FSM still goes to IDLE.
- `start` while `busy` is ignored and not queued.
- `abort` and `start` in the same cycle in IDLE: the start is taken.

## Timing
- Reset values, and values while `rst_n` is low: state=IDLE; `out_valid`, `out_data`, `busy`, `done` and `remaining` are all 0.
- The LFSR register is not cleared by `rst_n`, but its value is masked by `out_valid`=0 and is always reloaded in LOAD.
- Reset may be asserted mid-burst. The block returns to IDLE immediately (asynchronously) with no `done`.
- Cycle 0: `start` sampled. Cycle 1: LOAD, `busy`=1. Cycle 2: first word valid, `out_data`=seed.
- With `out_ready` held at 1, one word is emitted per cycle. The last word is at cycle count+1 and `done` is at cycle count+2. `busy` falls at cycle count+3.
- `count`=0: `done` at cycle 1, `busy` high only in cycle 1.
- All outputs are registered or decoded from the state register. There is no combinational path from `out_ready` to `out_valid`.

## Test plan
- Reset with `rst_n`=0 during STREAM: all outputs go to 0 immediately. After release, the block is in IDLE and a new `start` works normally.
- `start`, seed=0x01, count=4, `out_ready`=1: cycles 2–5 give 0x01, 0xB8, 0x5C, 0x2E; `done`=1 in cycle 6; `busy` is 1 for cycles 1–6.
- seed=0x00, count=2: words 0xFF, 0xC7, then `done`.
- Backpressure:
  - Stimulus: seed=0x01, count=6, `out_ready` toggling 1,0,0,1,… (stalls in between).
  - Accepted sequence: 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
  - `out_data` stays stable during stalls.
  - `done` arrives only after the 6th handshake.
- `abort` in STREAM after 2 accepted words: `out_valid` is 0 the next cycle and no `done` fires. Re-`start` with seed=0x01 restarts at 0x01.
- count=0: `done` pulse in cycle 1 and `out_valid` is never asserted. A `start` pulse during `busy` is ignored, and the word count is unchanged.
